// File: rtl/apple_spawn_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apple_spawn_if : body-memory read bus between the spawn controller and RAM |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface apple_spawn_if #(
  parameter int H_LOGIC_WIDTH = 5,
  parameter int V_LOGIC_WIDTH = 5
);
  logic                     body_rd;
  logic [9:0]               body_addr;
  logic [H_LOGIC_WIDTH-1:0] body_x;
  logic [V_LOGIC_WIDTH-1:0] body_y;

  modport master (output body_rd, body_addr, input body_x, body_y);
  modport slave  (input body_rd, body_addr, output body_x, body_y);
endinterface
`default_nettype wire

// File: rtl/apple_spawn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apple_spawn_ctrl : LFSR-driven apple placement, rejecting body collisions   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module apple_spawn_ctrl #(
  parameter int                       H_LOGIC_WIDTH = 5,
  parameter int                       V_LOGIC_WIDTH = 5,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX   = 5'd23,
  parameter int                       MAX_RETRY     = 15,
  parameter logic [15:0]              SEED          = 16'hACE1
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     start,
  input  wire logic [9:0]               length,
  apple_spawn_if.master                 body,
  output logic [H_LOGIC_WIDTH-1:0]      apple_x,
  output logic [V_LOGIC_WIDTH-1:0]      apple_y,
  output logic                          apple_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          fail,
  output logic [H_LOGIC_WIDTH-1:0]      cand_x,
  output logic [V_LOGIC_WIDTH-1:0]      cand_y,
  output logic [3:0]                    retry_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DRAW = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  localparam logic [4:0] RETRY_LIMIT = 5'(MAX_RETRY);
  localparam logic [9:0] ADDR_MAX    = 10'h3FF;

  logic [2:0]               state_q, state_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [H_LOGIC_WIDTH-1:0] cand_x_q, cand_x_d;
  logic [V_LOGIC_WIDTH-1:0] cand_y_q, cand_y_d;
  logic [H_LOGIC_WIDTH-1:0] apple_x_q, apple_x_d;
  logic [V_LOGIC_WIDTH-1:0] apple_y_q, apple_y_d;
  logic [9:0]               len_q, len_d;
  logic [9:0]               addr_q, addr_d;
  logic                     rd_q, rd_d;
  logic                     cmp_vld_q, cmp_vld_d;
  logic [9:0]               cmp_idx_q, cmp_idx_d;
  logic [3:0]               retry_q, retry_d;
  logic                     fail_q, fail_d;
  logic                     done_q, busy_q, valid_q;

  logic                     w_fb;
  logic [H_LOGIC_WIDTH-1:0] w_draw_x;
  logic [V_LOGIC_WIDTH-1:0] w_draw_y;
  logic                     w_draw_ok;
  logic                     w_hit;
  logic                     w_last_cmp;
  logic                     w_at_limit;
  logic                     w_reject;

  assign w_fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign w_draw_x   = lfsr_q[H_LOGIC_WIDTH-1:0];
  assign w_draw_y   = lfsr_q[H_LOGIC_WIDTH +: V_LOGIC_WIDTH];
  assign w_draw_ok  = (w_draw_y <= V_LOGIC_MAX);
  // Returned body data lines up with the read issued one cycle earlier.
  assign w_hit      = cmp_vld_q && (body.body_x == cand_x_q) && (body.body_y == cand_y_q);
  assign w_last_cmp = cmp_vld_q && (cmp_idx_q == (len_q - 10'd1));
  assign w_at_limit = ({1'b0, retry_q} >= RETRY_LIMIT);
  assign w_reject   = ((state_q == S_DRAW) && !w_draw_ok) || ((state_q == S_SCAN) && w_hit);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[14:0], w_fb};
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    len_d     = len_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    cmp_vld_d = 1'b0;
    cmp_idx_d = cmp_idx_q;
    retry_d   = retry_q;
    fail_d    = fail_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRAW;
          retry_d = 4'd0;
          fail_d  = 1'b0;
        end
      end
      S_DRAW: begin
        cand_x_d = w_draw_x;
        cand_y_d = w_draw_y;
        if (w_draw_ok) begin
          len_d = length;
          if (length == 10'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            rd_d    = 1'b1;
            addr_d  = 10'd0;
          end
        end
      end
      S_SCAN: begin
        cmp_vld_d = rd_q;
        cmp_idx_d = addr_q;
        if (rd_q && (addr_q != (len_q - 10'd1)) && (addr_q != ADDR_MAX)) begin
          rd_d   = 1'b1;
          addr_d = addr_q + 10'd1;
        end
        if (w_last_cmp && !w_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        apple_x_d = cand_x_q;
        apple_y_d = cand_y_q;
        state_d   = S_IDLE;
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A rejected draw or a body hit both cost one retry; in-flight reads are dropped.
    if (w_reject) begin
      rd_d      = 1'b0;
      cmp_vld_d = 1'b0;
      if (w_at_limit) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
      end else begin
        state_d = S_DRAW;
        retry_d = retry_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      apple_x_q <= H_LOGIC_WIDTH'(15);
      apple_y_q <= V_LOGIC_WIDTH'(15);
      len_q     <= 10'd0;
      addr_q    <= 10'd0;
      rd_q      <= 1'b0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= 10'd0;
      retry_q   <= 4'd0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      retry_q   <= retry_d;
      fail_q    <= fail_d;
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      valid_q   <= (state_d == S_IDLE);
    end
  end

  assign body.body_rd   = rd_q;
  assign body.body_addr = addr_q;
  assign apple_x        = apple_x_q;
  assign apple_y        = apple_y_q;
  assign apple_valid    = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign cand_x         = cand_x_q;
  assign cand_y         = cand_y_q;
  assign retry_cnt      = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_apple_spawn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apple_spawn_ctrl : scoreboard bench for the apple spawn controller      |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_apple_spawn_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    int         kind;     // 0 = done, 1 = fail
    int         cyc;
    logic [4:0] ax;
    logic [4:0] ay;
    int         retries;
  } exp_t;

  typedef struct {
    int t;
    int a;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] length = 10'd0;
  logic [4:0] apple_x, apple_y, cand_x, cand_y;
  logic       apple_valid, busy, done, fail;
  logic [3:0] retry_cnt;

  apple_spawn_if #(.H_LOGIC_WIDTH(5), .V_LOGIC_WIDTH(5)) bus ();

  apple_spawn_ctrl #(
    .H_LOGIC_WIDTH(5), .V_LOGIC_WIDTH(5), .V_LOGIC_MAX(5'd23),
    .MAX_RETRY(15), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .length(length), .body(bus),
    .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
    .busy(busy), .done(done), .fail(fail),
    .cand_x(cand_x), .cand_y(cand_y), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  // Body RAM: (0,0) everywhere, except echo of the candidate for the collision modes.
  int mode = 0;
  int a2_base = 0;
  int a2_reads = 0;
  always @(posedge clk) begin
    if (bus.body_rd) begin
      if ((mode == 2 && bus.body_addr == 10'd0) ||
          (mode == 1 && bus.body_addr == 10'd2 && a2_reads == a2_base)) begin
        bus.body_x <= cand_x;
        bus.body_y <= cand_y;
      end else begin
        bus.body_x <= 5'd0;
        bus.body_y <= 5'd0;
      end
      if (bus.body_addr == 10'd2) a2_reads <= a2_reads + 1;
    end
  end

  rd_t rdlog[$];
  always @(negedge clk) if (!rst && bus.body_rd) rdlog.push_back('{cnt, int'(bus.body_addr)});

  exp_t sb[$];
  logic [4:0] mdl_ax = 5'd15;
  logic [4:0] mdl_ay = 5'd15;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-level reference: l1 is the LFSR value in the first DRAW cycle, t0 its cnt.
  function automatic exp_t predict(input logic [15:0] l1, input int t0, input int len,
                                   input int md, input logic [4:0] pax, input logic [4:0] pay);
    exp_t e;
    logic [15:0] l;
    logic [4:0] cx, cy, bx, by;
    int c, r, kc, adv;
    bit armed;
    l = l1; c = 1; r = 0; armed = (md == 1);
    e.kind = 0; e.cyc = -1; e.ax = pax; e.ay = pay; e.retries = 0;
    for (int g = 0; g < 64; g++) begin
      cx = l[4:0];
      cy = l[9:5];
      if (cy > 5'd23) begin
        adv = 1;
      end else if (len == 0) begin
        e.cyc = t0 + c; e.ax = cx; e.ay = cy; e.retries = r;
        return e;
      end else begin
        kc = -1;
        for (int k = 0; k < len && kc < 0; k++) begin
          bx = 5'd0; by = 5'd0;
          if ((md == 2 && k == 0) || (md == 1 && armed && k == 2)) begin
            bx = cx; by = cy;
          end
          if (bx == cx && by == cy) kc = k;
        end
        if (kc < 0) begin
          e.cyc = t0 + c + len + 1; e.ax = cx; e.ay = cy; e.retries = r;
          return e;
        end
        if (md == 1 && armed && kc + 1 >= 2 && len > 2) armed = 1'b0;
        adv = kc + 3;
      end
      if (r == 15) begin
        e.kind = 1; e.cyc = t0 + c + adv - 1; e.retries = 15;
        return e;
      end
      r++;
      c += adv;
      for (int i = 0; i < adv; i++) l = lfsr_step(l);
    end
    return e;
  endfunction

  // Called at a negedge; the start pulse is sampled at the following posedge.
  task automatic issue(input int len, input int md, input bit push, output int t0);
    logic [15:0] l1;
    exp_t e;
    for (int w = 0; w < 200; w++) begin
      l1 = lfsr_step(m_lfsr);
      if (l1[9:5] <= 5'd23 && l1[9:0] != 10'd0) break;
      @(negedge clk);
    end
    length = 10'(len);
    mode   = md;
    a2_base = a2_reads;
    t0 = cnt + 1;
    e = predict(lfsr_step(m_lfsr), t0, len, md, mdl_ax, mdl_ay);
    if (push) begin
      sb.push_back(e);
      if (e.kind == 0) begin mdl_ax = e.ax; mdl_ay = e.ay; end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_in_time", (n < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every done pulse or fail rising edge consumes one expectation.
  initial begin
    bit fail_prev;
    int kind;
    exp_t e;
    fail_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (done || (fail && !fail_prev))) begin
        kind = done ? 0 : 1;
        if (sb.size() == 0) begin
          chk("event_expected", kind, -1);
        end else begin
          e = sb.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cnt, e.cyc);
          @(negedge clk);
          chk("apple_x", apple_x, e.ax);
          chk("apple_y", apple_y, e.ay);
          chk("apple_valid_after", apple_valid, 1);
          chk("retry_cnt", retry_cnt, e.retries);
          chk("fail_flag", fail, e.kind);
        end
      end
      fail_prev = fail;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_apple_x", apple_x, 15);
    chk("rst_apple_y", apple_y, 15);
    chk("rst_apple_valid", apple_valid, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fail", fail, 0);
    chk("rst_body_rd", bus.body_rd, 0);
    chk("rst_retry", retry_cnt, 0);

    // Empty body, then a one-segment body.
    issue(0, 0, 1'b1, t0);
    wait_idle();
    issue(1, 0, 1'b1, t0);
    wait_idle();

    // Clear four-segment body: reads 0..3 on consecutive cycles starting cycle 2.
    rdlog.delete();
    issue(4, 0, 1'b1, t0);
    wait_idle();
    chk("clear_reads", rdlog.size(), 4);
    for (int i = 0; i < 4 && i < rdlog.size(); i++) begin
      chk("clear_addr", rdlog[i].a, i);
      chk("clear_rd_cycle", rdlog[i].t, t0 + 1 + i);
    end

    // Single collision at address 2.
    rdlog.delete();
    issue(5, 1, 1'b1, t0);
    wait_idle();
    chk("coll_reads_ge5", (rdlog.size() >= 5), 1);
    if (rdlog.size() >= 5) begin
      chk("coll_addr3", rdlog[3].a, 3);
      chk("coll_rescan_addr", rdlog[4].a, 0);
      chk("coll_rd_gap", ((rdlog[4].t - rdlog[3].t) >= 2), 1);
    end
    chk("coll_retry_ge1", (retry_cnt >= 4'd1), 1);

    // Full collision: retry limit reached, apple kept, next start clears fail.
    issue(3, 2, 1'b1, t0);
    wait_idle();
    chk("full_fail", fail, 1);
    chk("full_valid", apple_valid, 1);
    chk("full_apple_x", apple_x, mdl_ax);
    issue(0, 0, 1'b1, t0);
    chk("start_clears_fail", fail, 0);
    chk("start_clears_retry", retry_cnt, 0);
    wait_idle();

    // Start pulse while busy must be ignored.
    issue(6, 0, 1'b1, t0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("busy_ignored_idle", busy, 0);

    // Reset at scan index 5 aborts without a done pulse.
    begin
      int n;
      n = 0;
      issue(10, 0, 1'b0, t0);
      while (!(bus.body_rd && bus.body_addr == 10'd5) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("reach_index5", (n < 200), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_apple_x", apple_x, 15);
      chk("mid_rst_apple_y", apple_y, 15);
      chk("mid_rst_valid", apple_valid, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_body_rd", bus.body_rd, 0);
      chk("mid_rst_body_addr", bus.body_addr, 0);
      chk("mid_rst_cand", {cand_x, cand_y}, 0);
      mdl_ax = 5'd15;
      mdl_ay = 5'd15;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_apple_x", apple_x, 15);
      chk("post_rst_busy", busy, 0);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
